// File: rtl/bytecode_pkg.sv
// Shared opcode values, instruction class codes and decoder FSM state encoding
// for the bytecode decoder and its opcode lookup table.
package bytecode_pkg;

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_ICONST_M1 = 8'h02;
    localparam logic [7:0] OP_ICONST_0  = 8'h03;
    localparam logic [7:0] OP_ICONST_1  = 8'h04;
    localparam logic [7:0] OP_ICONST_2  = 8'h05;
    localparam logic [7:0] OP_ICONST_3  = 8'h06;
    localparam logic [7:0] OP_ICONST_4  = 8'h07;
    localparam logic [7:0] OP_ICONST_5  = 8'h08;
    localparam logic [7:0] OP_BIPUSH    = 8'h10;
    localparam logic [7:0] OP_SIPUSH    = 8'h11;
    localparam logic [7:0] OP_IADD      = 8'h60;
    localparam logic [7:0] OP_ISUB      = 8'h64;
    localparam logic [7:0] OP_IMUL      = 8'h68;
    localparam logic [7:0] OP_IDIV      = 8'h6C;
    localparam logic [7:0] OP_DDIV      = 8'h6F;
    localparam logic [7:0] OP_I2B       = 8'h91;
    localparam logic [7:0] OP_IASTORE   = 8'h4F;
    localparam logic [7:0] OP_LASTORE   = 8'h50;

    localparam logic [2:0] CLS_NOP     = 3'd0;
    localparam logic [2:0] CLS_CONST   = 3'd1;
    localparam logic [2:0] CLS_ARITH   = 3'd2;
    localparam logic [2:0] CLS_CONV    = 3'd3;
    localparam logic [2:0] CLS_STORE   = 3'd4;
    localparam logic [2:0] CLS_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OP1   = 2'd1,
        ST_OP2   = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

endpackage

// File: rtl/bytecode_lut.sv
// Combinational opcode classifier: operand byte count, class, signed
// operand-stack delta and illegal flag for one opcode byte.
module bytecode_lut
    import bytecode_pkg::*;
#(
    parameter int BYTE    = 8,
    parameter int DELTA_W = 4
) (
    input  logic [BYTE-1:0]    i_opcode,
    output logic [1:0]         o_len,
    output logic [2:0]         o_class,
    output logic [DELTA_W-1:0] o_delta,
    output logic               o_illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        o_len     = 2'd0;
        o_class   = CLS_ILLEGAL;
        o_delta   = '0;
        o_illegal = 1'b1;
        case (i_opcode)
            OP_NOP: begin
                o_class   = CLS_NOP;
                o_illegal = 1'b0;
            end
            OP_ICONST_M1, OP_ICONST_0, OP_ICONST_1, OP_ICONST_2,
            OP_ICONST_3, OP_ICONST_4, OP_ICONST_5: begin
                o_class   = CLS_CONST;
                o_delta   = DELTA_W'(1);
                o_illegal = 1'b0;
            end
            OP_BIPUSH, OP_SIPUSH: begin
                o_len     = (i_opcode == OP_BIPUSH) ? 2'd1 : 2'd2;
                o_class   = CLS_CONST;
                o_delta   = DELTA_W'(1);
                o_illegal = 1'b0;
            end
            OP_IADD, OP_ISUB, OP_IMUL, OP_IDIV: begin
                o_class   = CLS_ARITH;
                o_delta   = DELTA_W'(-1);
                o_illegal = 1'b0;
            end
            OP_DDIV: begin
                // Double operands occupy two stack slots each.
                o_class   = CLS_ARITH;
                o_delta   = DELTA_W'(-2);
                o_illegal = 1'b0;
            end
            OP_I2B: begin
                o_class   = CLS_CONV;
                o_illegal = 1'b0;
            end
            OP_IASTORE, OP_LASTORE: begin
                o_class   = CLS_STORE;
                o_delta   = (i_opcode == OP_IASTORE) ? DELTA_W'(-3) : DELTA_W'(-4);
                o_illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bytecode_decoder.sv
// Bytecode decoder: accepts opcode plus 0-2 immediate bytes, issues one decoded
// instruction over valid/ready. Define DECODER_STATS_EN for issue/illegal counters.
module bytecode_decoder
    import bytecode_pkg::*;
#(
    parameter int BYTE      = 8,
    parameter int OPERAND_W = 16,
    parameter int DELTA_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_for_decoder,
    input  logic [BYTE-1:0]      data_for_decoder,
    output logic                 ready_from_decoder,
    output logic                 instr_valid,
    input  logic                 exec_ready,
    output logic [BYTE-1:0]      instr_opcode,
    output logic [OPERAND_W-1:0] instr_operand,
    output logic [2:0]           instr_class,
    output logic [DELTA_W-1:0]   instr_delta,
    output logic                 instr_illegal
`ifdef DECODER_STATS_EN
    ,
    output logic [15:0]          instr_count,
    output logic [7:0]           illegal_count
`endif
);

    logic [1:0]           w_len;
    logic [2:0]           w_class;
    logic [DELTA_W-1:0]   w_delta;
    logic                 w_illegal;
    logic [BYTE-1:0]      w_iconst_k;
    logic [OPERAND_W-1:0] w_byte_sext;

    state_t               r_state;
    logic                 r_ready;
    logic                 r_valid;
    logic [1:0]           r_len;
    logic [BYTE-1:0]      r_opcode;
    logic [OPERAND_W-1:0] r_operand;
    logic [2:0]           r_class;
    logic [DELTA_W-1:0]   r_delta;
    logic                 r_illegal;

    bytecode_lut #(
        .BYTE    (BYTE),
        .DELTA_W (DELTA_W)
    ) u_lut (
        .i_opcode  (data_for_decoder),
        .o_len     (w_len),
        .o_class   (w_class),
        .o_delta   (w_delta),
        .o_illegal (w_illegal)
    );

    // iconst_m1..iconst_5 encode their value as opcode - 3.
    assign w_iconst_k  = data_for_decoder - BYTE'(3);
    assign w_byte_sext = {{(OPERAND_W-BYTE){data_for_decoder[BYTE-1]}}, data_for_decoder};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_valid   <= 1'b0;
            r_len     <= 2'd0;
            r_opcode  <= '0;
            r_operand <= '0;
            r_class   <= '0;
            r_delta   <= '0;
            r_illegal <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            case (r_state)
                ST_IDLE: if (start_for_decoder) begin
                    r_opcode  <= data_for_decoder;
                    r_len     <= w_len;
                    r_class   <= w_class;
                    r_delta   <= w_delta;
                    r_illegal <= w_illegal;
                    if (w_class == CLS_CONST && w_len == 2'd0)
                        r_operand <= {{(OPERAND_W-BYTE){w_iconst_k[BYTE-1]}}, w_iconst_k};
                    else
                        r_operand <= '0;
                    if (w_len == 2'd0) begin
                        r_state <= ST_ISSUE;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_OP1;
                    end
                end
                ST_OP1: if (start_for_decoder) begin
                    // For sipush this sign-extended high byte is shifted up in OP2.
                    r_operand <= w_byte_sext;
                    if (r_len == 2'd1) begin
                        r_state <= ST_ISSUE;
                        r_ready <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= ST_OP2;
                    end
                end
                ST_OP2: if (start_for_decoder) begin
                    r_operand <= {r_operand[OPERAND_W-BYTE-1:0], data_for_decoder};
                    r_state   <= ST_ISSUE;
                    r_ready   <= 1'b0;
                    r_valid   <= 1'b1;
                end
                ST_ISSUE: if (exec_ready) begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_from_decoder = r_ready;
    assign instr_valid        = r_valid;
    assign instr_opcode       = r_opcode;
    assign instr_operand      = r_operand;
    assign instr_class        = r_class;
    assign instr_delta        = r_delta;
    assign instr_illegal      = r_illegal;

`ifdef DECODER_STATS_EN
    logic [15:0] r_instr_count;
    logic [7:0]  r_illegal_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_count   <= '0;
            r_illegal_count <= '0;
        end else if (r_valid && exec_ready) begin
            r_instr_count <= r_instr_count + 16'd1;
            if (r_illegal)
                r_illegal_count <= r_illegal_count + 8'd1;
        end
    end

    assign instr_count   = r_instr_count;
    assign illegal_count = r_illegal_count;
`endif

endmodule

// File: tb/tb_bytecode_decoder.sv
// Directed bench for bytecode_decoder: table of single instructions plus
// hand-written stall, back-to-back and mid-operation reset sequences.
module tb_bytecode_decoder;

    logic        clk;
    logic        rst_n;
    logic        start_for_decoder;
    logic [7:0]  data_for_decoder;
    logic        ready_from_decoder;
    logic        instr_valid;
    logic        exec_ready;
    logic [7:0]  instr_opcode;
    logic [15:0] instr_operand;
    logic [2:0]  instr_class;
    logic [3:0]  instr_delta;
    logic        instr_illegal;
`ifdef DECODER_STATS_EN
    logic [15:0] instr_count;
    logic [7:0]  illegal_count;
    int          exp_count;
    int          exp_illegal_count;
`endif

    int checks = 0;
    int errors = 0;

    bytecode_decoder dut (
        .clk                (clk),
        .reset              (rst_n),
        .start_for_decoder  (start_for_decoder),
        .data_for_decoder   (data_for_decoder),
        .ready_from_decoder (ready_from_decoder),
        .instr_valid        (instr_valid),
        .exec_ready         (exec_ready),
        .instr_opcode       (instr_opcode),
        .instr_operand      (instr_operand),
        .instr_class        (instr_class),
        .instr_delta        (instr_delta),
        .instr_illegal      (instr_illegal)
`ifdef DECODER_STATS_EN
        ,
        .instr_count        (instr_count),
        .illegal_count      (illegal_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          nbytes;
        logic [23:0] bytes;
        logic        er_during_send;
        logic [7:0]  opcode;
        logic [15:0] operand;
        logic [2:0]  cls;
        logic [3:0]  delta;
        logic        illegal;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input int n, input logic [23:0] b, input logic er,
                                input logic [15:0] opnd, input logic [2:0] cls,
                                input logic [3:0] d, input logic ill);
        vec_t v;
        v.nbytes         = n;
        v.bytes          = b;
        v.er_during_send = er;
        v.opcode         = b[23:16];
        v.operand        = opnd;
        v.cls            = cls;
        v.delta          = d;
        v.illegal        = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, ".valid"},   32'(instr_valid), 32'd1);
        check({tag, ".ready"},   32'(ready_from_decoder), 32'd0);
        check({tag, ".opcode"},  32'(instr_opcode), 32'(v.opcode));
        check({tag, ".operand"}, 32'(instr_operand), 32'(v.operand));
        check({tag, ".class"},   32'(instr_class), 32'(v.cls));
        check({tag, ".delta"},   32'(instr_delta), 32'(v.delta));
        check({tag, ".illegal"}, 32'(instr_illegal), 32'(v.illegal));
    endtask

    // Sends all bytes of one instruction, checks the issue, then retires it.
    task automatic run_vec(input string tag, input vec_t v);
        for (int i = 0; i < v.nbytes; i++) begin
            int t = 0;
            while (!ready_from_decoder && t < 20) begin
                step();
                t++;
            end
            if (t == 20) check({tag, ".ready_timeout"}, 32'(ready_from_decoder), 32'd1);
            exec_ready        = v.er_during_send;
            start_for_decoder = 1'b1;
            data_for_decoder  = v.bytes[23-8*i -: 8];
            step();
            if (i < v.nbytes - 1)
                check({tag, ".no_early_valid"}, 32'(instr_valid), 32'd0);
        end
        start_for_decoder = 1'b0;
        exec_ready        = 1'b0;
        check_outputs(tag, v);
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        check({tag, ".retire_valid"}, 32'(instr_valid), 32'd0);
        check({tag, ".retire_ready"}, 32'(ready_from_decoder), 32'd1);
`ifdef DECODER_STATS_EN
        exp_count++;
        if (v.illegal) exp_illegal_count++;
`endif
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ready"},   32'(ready_from_decoder), 32'd1);
        check({tag, ".valid"},   32'(instr_valid), 32'd0);
        check({tag, ".illegal"}, 32'(instr_illegal), 32'd0);
        check({tag, ".opcode"},  32'(instr_opcode), 32'd0);
        check({tag, ".operand"}, 32'(instr_operand), 32'd0);
        check({tag, ".class"},   32'(instr_class), 32'd0);
        check({tag, ".delta"},   32'(instr_delta), 32'd0);
    endtask

    initial begin
        vec_t ddiv_v;
        vec_t i2b_v;
        vecs[0]  = mk(1, 24'h00_0000, 1'b0, 16'h0000, 3'd0, 4'h0, 1'b0); // nop
        vecs[1]  = mk(1, 24'h02_0000, 1'b1, 16'hFFFF, 3'd1, 4'h1, 1'b0); // iconst_m1
        vecs[2]  = mk(1, 24'h03_0000, 1'b1, 16'h0000, 3'd1, 4'h1, 1'b0); // iconst_0
        vecs[3]  = mk(1, 24'h08_0000, 1'b0, 16'h0005, 3'd1, 4'h1, 1'b0); // iconst_5
        vecs[4]  = mk(2, 24'h10_8000, 1'b1, 16'hFF80, 3'd1, 4'h1, 1'b0); // bipush -128
        vecs[5]  = mk(2, 24'h10_7F00, 1'b0, 16'h007F, 3'd1, 4'h1, 1'b0); // bipush 127
        vecs[6]  = mk(3, 24'h11_FF85, 1'b1, 16'hFF85, 3'd1, 4'h1, 1'b0); // sipush
        vecs[7]  = mk(3, 24'h11_1234, 1'b0, 16'h1234, 3'd1, 4'h1, 1'b0); // sipush
        vecs[8]  = mk(1, 24'h60_0000, 1'b0, 16'h0000, 3'd2, 4'hF, 1'b0); // iadd
        vecs[9]  = mk(1, 24'h64_0000, 1'b1, 16'h0000, 3'd2, 4'hF, 1'b0); // isub
        vecs[10] = mk(1, 24'h68_0000, 1'b0, 16'h0000, 3'd2, 4'hF, 1'b0); // imul
        vecs[11] = mk(1, 24'h6C_0000, 1'b0, 16'h0000, 3'd2, 4'hF, 1'b0); // idiv
        vecs[12] = mk(1, 24'h6F_0000, 1'b0, 16'h0000, 3'd2, 4'hE, 1'b0); // ddiv
        vecs[13] = mk(1, 24'h91_0000, 1'b0, 16'h0000, 3'd3, 4'h0, 1'b0); // i2b
        vecs[14] = mk(1, 24'h4F_0000, 1'b0, 16'h0000, 3'd4, 4'hD, 1'b0); // iastore
        vecs[15] = mk(1, 24'h50_0000, 1'b0, 16'h0000, 3'd4, 4'hC, 1'b0); // lastore
        vecs[16] = mk(1, 24'hCA_0000, 1'b0, 16'h0000, 3'd7, 4'h0, 1'b1); // illegal
        vecs[17] = mk(1, 24'h01_0000, 1'b0, 16'h0000, 3'd7, 4'h0, 1'b1); // below iconst
        vecs[18] = mk(1, 24'h09_0000, 1'b1, 16'h0000, 3'd7, 4'h0, 1'b1); // above iconst
        vecs[19] = mk(1, 24'hFF_0000, 1'b0, 16'h0000, 3'd7, 4'h0, 1'b1); // 0xFF

        rst_n             = 1'b0;
        start_for_decoder = 1'b0;
        data_for_decoder  = 8'h00;
        exec_ready        = 1'b0;
`ifdef DECODER_STATS_EN
        exp_count         = 0;
        exp_illegal_count = 0;
`endif
        repeat (3) step();
        check_reset_values("rst_hold");
        rst_n = 1'b1;
        step();
        check_reset_values("rst_release");

        for (int i = 0; i < NVEC; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // ddiv stalled by execute while i2b is held on the fetch side.
        ddiv_v = mk(1, 24'h6F_0000, 1'b0, 16'h0000, 3'd2, 4'hE, 1'b0);
        i2b_v  = mk(1, 24'h91_0000, 1'b0, 16'h0000, 3'd3, 4'h0, 1'b0);
        start_for_decoder = 1'b1;
        data_for_decoder  = 8'h6F;
        step();
        data_for_decoder  = 8'h91;
        for (int c = 0; c < 5; c++) begin
            check_outputs($sformatf("stall%0d", c), ddiv_v);
            step();
        end
        check_outputs("stall_end", ddiv_v);
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        check("stall.retire_valid", 32'(instr_valid), 32'd0);
        check("stall.retire_ready", 32'(ready_from_decoder), 32'd1);
        step();
        start_for_decoder = 1'b0;
        check_outputs("held_i2b", i2b_v);
        exec_ready = 1'b1;
        step();
        exec_ready = 1'b0;
        check("held_i2b.retire_valid", 32'(instr_valid), 32'd0);
`ifdef DECODER_STATS_EN
        exp_count += 2;
        check("stats.count_pre", 32'(instr_count), 32'(exp_count));
        check("stats.illegal_pre", 32'(illegal_count), 32'(exp_illegal_count));
`endif

        // Reset while collecting sipush operands (OP1 then OP2).
        start_for_decoder = 1'b1;
        data_for_decoder  = 8'h11;
        step();
        data_for_decoder  = 8'hFF;
        step();
        start_for_decoder = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_midop");
        step();
        rst_n = 1'b1;
        step();
        check_reset_values("rst_midop_release");

        // Reset while an instruction waits in ISSUE.
        start_for_decoder = 1'b1;
        data_for_decoder  = 8'h04;
        step();
        start_for_decoder = 1'b0;
        check("issue_pre_rst.valid", 32'(instr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_values("rst_issue");
        step();
        rst_n = 1'b1;
        step();
`ifdef DECODER_STATS_EN
        exp_count         = 0;
        exp_illegal_count = 0;
        check("stats.count_rst", 32'(instr_count), 32'd0);
`endif

        run_vec("post_rst_lastore", vecs[15]);
        run_vec("post_rst_illegal", vecs[16]);
`ifdef DECODER_STATS_EN
        check("stats.count", 32'(instr_count), 32'(exp_count));
        check("stats.illegal", 32'(illegal_count), 32'(exp_illegal_count));
        check("stats.count_is_2", 32'(instr_count), 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
